mul_div_unit: RTL and testbench

Iterative, parametrised multiply/divide unit implementing the RV32M operation set alongside the single-cycle integer ALU in the MCU datapath. It accepts one operation per START pulse, computes it over multiple cycles with a shift/add multiplier or a restoring divider, and returns the result with a one-cycle DONE pulse. The control unit stalls the pipeline while BUSY is high.

---
 rtl/mul_div_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Iterative RV32M multiply/divide unit. One operation is accepted per start
// pulse while idle. Multiplies run a shift/add loop and divides run a
// restoring loop, one bit per cycle over XLEN cycles. A final fix-up cycle
// applies sign correction and loads the result. Divide-by-zero and signed
// overflow skip the loop and go straight to the fix-up cycle.
//
// Ports
//   clk     : clock, rising edge active
//   rst_n   : asynchronous active-low reset, aborts any operation
//   start   : operation request, only sampled while idle
//   a       : operand 1 (multiplicand / dividend)
//   b       : operand 2 (multiplier / divisor)
//   md_fun  : RISC-V funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   result  : registered result, held until the next completion
//   busy    : high while an operation is in progress
//   done    : one-cycle pulse, result is valid in the same cycle
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      md_fun,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t            state;
    logic [2:0]        fun_q;
    logic              sign_a;
    logic              sign_b;
    logic              special_q;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [CW-1:0]     cnt;

    logic              a_signed_in;
    logic              b_signed_in;
    logic              neg_a_in;
    logic              neg_b_in;
    logic [XLEN-1:0]   a_mag_in;
    logic [XLEN-1:0]   b_mag_in;
    logic              b_zero_in;
    logic              div_ovf_in;
    logic              special_in;
    logic [XLEN-1:0]   special_val;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   next_hi;
    logic [XLEN-1:0]   next_lo;

    logic [2*XLEN-1:0] prod_full;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [XLEN-1:0]   fix_val;

    // Decode the incoming request: operand signedness, magnitudes and the
    // special cases that bypass the iterative loop. The magnitude of the
    // most-negative value wraps to itself, which is correct when read as
    // unsigned.
    always_comb begin
        a_signed_in = (md_fun == 3'b001) || (md_fun == 3'b010) ||
                      (md_fun == 3'b100) || (md_fun == 3'b110);
        b_signed_in = (md_fun == 3'b001) || (md_fun == 3'b100) ||
                      (md_fun == 3'b110);
        neg_a_in    = a_signed_in && a[XLEN-1];
        neg_b_in    = b_signed_in && b[XLEN-1];
        a_mag_in    = neg_a_in ? (~a + XLEN'(1)) : a;
        b_mag_in    = neg_b_in ? (~b + XLEN'(1)) : b;
        b_zero_in   = (b == '0);
        div_ovf_in  = !md_fun[0] && (a == MIN_NEG) && (b == '1);
        special_in  = md_fun[2] && (b_zero_in || div_ovf_in);
        special_val = '0;
        if (b_zero_in) begin
            special_val = md_fun[1] ? a : '1;
        end else begin
            special_val = md_fun[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration of either loop. Multiply: acc_hi:acc_lo is the product
    // register with the multiplier in the low half. Divide: acc_hi is the
    // partial remainder and acc_lo shifts dividend bits out and quotient
    // bits in.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        rem_sh  = {acc_hi, acc_lo[XLEN-1]};
        diff    = rem_sh - {1'b0, opnd};
        next_hi = acc_hi;
        next_lo = acc_lo;
        if (!fun_q[2]) begin
            next_hi = mul_sum[XLEN:1];
            next_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            next_hi = diff[XLEN-1:0];
            next_lo = {acc_lo[XLEN-2:0], 1'b1};
        end else begin
            next_hi = rem_sh[XLEN-1:0];
            next_lo = {acc_lo[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and result selection for the fix-up cycle. The
    // remainder follows the dividend's sign only.
    always_comb begin
        prod_full = {acc_hi, acc_lo};
        prod_fix  = (sign_a ^ sign_b) ? (~prod_full + (2*XLEN)'(1)) : prod_full;
        q_fix     = (sign_a ^ sign_b) ? (~acc_lo + XLEN'(1)) : acc_lo;
        r_fix     = sign_a ? (~acc_hi + XLEN'(1)) : acc_hi;
        fix_val   = '0;
        if (special_q) begin
            fix_val = acc_lo;
        end else begin
            case (fun_q)
                3'b000:                 fix_val = prod_fix[XLEN-1:0];
                3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
                3'b100, 3'b101:         fix_val = q_fix;
                default:                fix_val = r_fix;
            endcase
        end
    end

    // Control FSM with all datapath registers. A special case parks its
    // final value in acc_lo so the fix-up cycle only has to copy it out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fun_q     <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            special_q <= 1'b0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            result    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        fun_q     <= md_fun;
                        sign_a    <= neg_a_in;
                        sign_b    <= neg_b_in;
                        special_q <= special_in;
                        busy      <= 1'b1;
                        acc_hi    <= '0;
                        if (special_in) begin
                            acc_lo <= special_val;
                            opnd   <= '0;
                            cnt    <= '0;
                            state  <= FIX;
                        end else begin
                            cnt   <= CW'(XLEN);
                            state <= CALC;
                            if (md_fun[2]) begin
                                acc_lo <= a_mag_in;
                                opnd   <= b_mag_in;
                            end else begin
                                acc_lo <= b_mag_in;
                                opnd   <= a_mag_in;
                            end
                        end
                    end
                end
                CALC: begin
                    acc_hi <= next_hi;
                    acc_lo <= next_lo;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= fix_val;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//
// Self-checking bench for mul_div_unit. A 32-bit instance takes directed
// cases, handshake and reset scenarios and a short random run. An 8-bit
// instance takes a long random sweep. Expected values come from a
// wide-integer arithmetic model of the RV32M rules.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;

    logic        start32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [2:0]  fun32;
    logic [31:0] res32;
    logic        busy32;
    logic        done32;

    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [2:0]  fun8;
    logic [7:0]  res8;
    logic        busy8;
    logic        done8;

    int          n_assert;
    int          n_fail;
    logic [31:0] got;
    logic [31:0] got2;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rf;
    int          lat;
    int          lat2;
    bit          seen_done;

    mul_div_unit #(.XLEN(32)) dut32 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start32),
        .a      (a32),
        .b      (b32),
        .md_fun (fun32),
        .result (res32),
        .busy   (busy32),
        .done   (done32)
    );

    mul_div_unit #(.XLEN(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .md_fun (fun8),
        .result (res8),
        .busy   (busy8),
        .done   (done8)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if it does not hold.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request on the selected instance (called 1 time unit after
    // a rising edge), then waits a bounded number of edges for done.
    // lat is the number of edges after the accepting edge until done is
    // seen, or 0 if it never arrived.
    task automatic applyStimulus(input bit use8, input logic [2:0] fun,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 output logic [31:0] res, output int lat_o);
        if (use8) begin
            fun8 = fun; a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
        end else begin
            fun32 = fun; a32 = av; b32 = bv; start32 = 1'b1;
        end
        @(posedge clk); #1;
        start8  = 1'b0;
        start32 = 1'b0;
        lat_o = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (use8 ? done8 : done32) begin
                lat_o = i;
                break;
            end
        end
        res = use8 ? {24'h0, res8} : res32;
    endtask

    // Reference result from plain wide signed arithmetic. SystemVerilog
    // division truncates toward zero and % takes the dividend's sign,
    // matching RISC-V; the overflow case falls out of the masking.
    function automatic logic [31:0] ref_model(input logic [2:0] fun,
                                              input logic [31:0] av,
                                              input logic [31:0] bv,
                                              input int w);
        logic signed [127:0] x;
        logic signed [127:0] y;
        logic signed [127:0] p;
        logic [127:0]        mask;
        logic [127:0]        r;
        bit                  sa;
        bit                  sb;
        mask = (128'd1 << w) - 128'd1;
        sa   = (fun == 3'd1) || (fun == 3'd2) || (fun == 3'd4) || (fun == 3'd6);
        sb   = (fun == 3'd1) || (fun == 3'd4) || (fun == 3'd6);
        x    = {96'h0, av} & mask;
        y    = {96'h0, bv} & mask;
        if (sa && av[w-1]) x = x - (128'd1 << w);
        if (sb && bv[w-1]) y = y - (128'd1 << w);
        if (!fun[2]) begin
            p = x * y;
            if (fun == 3'd0) r = p & mask;
            else             r = (p >>> w) & mask;
        end else if (y == 0) begin
            r = fun[1] ? (x & mask) : mask;
        end else begin
            p = fun[1] ? (x % y) : (x / y);
            r = p & mask;
        end
        return r[31:0];
    endfunction

    // Edges from acceptance to done: 1 for the bypass cases, w+1 otherwise.
    function automatic int exp_lat(input logic [2:0] fun, input logic [31:0] av,
                                   input logic [31:0] bv, input int w);
        logic [31:0] mask;
        logic [31:0] minneg;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        minneg = 32'd1 << (w - 1);
        if (fun[2] && (((bv & mask) == 0) ||
            (!fun[0] && ((av & mask) == minneg) && ((bv & mask) == mask))))
            return 1;
        return w + 1;
    endfunction

    // Directed step sequence followed by the random runs.
    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start32  = 1'b0; a32 = '0; b32 = '0; fun32 = '0;
        start8   = 1'b0; a8  = '0; b8  = '0; fun8  = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_result", res32, 32'h0);
        checkOutput("reset_busy", {31'h0, busy32}, 32'h0);
        checkOutput("reset_done", {31'h0, done32}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] multiply variants");
        applyStimulus(0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, lat);
        checkOutput("mul_res", got, 32'h0000_0001);
        checkOutput("mul_lat", 32'(lat), 32'd33);
        checkOutput("mul_busy_at_done", {31'h0, busy32}, 32'h0);
        applyStimulus(0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, lat);
        checkOutput("mulh_res", got, 32'h0000_0000);
        checkOutput("mulh_lat", 32'(lat), 32'd33);
        applyStimulus(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, lat);
        checkOutput("mulhu_res", got, 32'hFFFF_FFFE);
        checkOutput("mulhu_lat", 32'(lat), 32'd33);
        applyStimulus(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, lat);
        checkOutput("mulhsu_res", got, 32'hFFFF_FFFF);
        checkOutput("mulhsu_lat", 32'(lat), 32'd33);

        $display("[TB] division");
        applyStimulus(0, 3'b100, 32'hFFFF_FFF9, 32'd2, got, lat);
        checkOutput("div_neg_res", got, 32'hFFFF_FFFD);
        checkOutput("div_neg_lat", 32'(lat), 32'd33);
        applyStimulus(0, 3'b110, 32'hFFFF_FFF9, 32'd2, got, lat);
        checkOutput("rem_neg_res", got, 32'hFFFF_FFFF);
        applyStimulus(0, 3'b101, 32'd7, 32'd2, got, lat);
        checkOutput("divu_res", got, 32'd3);
        applyStimulus(0, 3'b111, 32'hFFFF_FFF9, 32'd2, got, lat);
        checkOutput("remu_res", got, 32'd1);

        $display("[TB] special cases");
        applyStimulus(0, 3'b100, 32'd5, 32'd0, got, lat);
        checkOutput("div_by0_res", got, 32'hFFFF_FFFF);
        checkOutput("div_by0_lat", 32'(lat), 32'd1);
        applyStimulus(0, 3'b111, 32'd5, 32'd0, got, lat);
        checkOutput("remu_by0_res", got, 32'd5);
        checkOutput("remu_by0_lat", 32'(lat), 32'd1);
        applyStimulus(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, got, lat);
        checkOutput("div_ovf_res", got, 32'h8000_0000);
        checkOutput("div_ovf_lat", 32'(lat), 32'd1);
        applyStimulus(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, got, lat);
        checkOutput("rem_ovf_res", got, 32'h0);
        checkOutput("rem_ovf_lat", 32'(lat), 32'd1);

        $display("[TB] start while busy");
        fun32 = 3'b101; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (done32) begin
                lat = i;
                start32 = 1'b0;
                break;
            end
            start32 = i[0];
            fun32   = 3'b000;
            a32     = $urandom;
            b32     = $urandom;
        end
        start32 = 1'b0;
        checkOutput("busy_ignore_res", res32, 32'd14);
        checkOutput("busy_ignore_lat", 32'(lat), 32'd33);

        $display("[TB] back to back");
        applyStimulus(0, 3'b000, 32'd6, 32'd7, got, lat);
        applyStimulus(0, 3'b011, 32'h8000_0000, 32'd4, got2, lat2);
        checkOutput("b2b_first_res", got, 32'd42);
        checkOutput("b2b_second_res", got2, 32'd2);
        checkOutput("b2b_second_lat", 32'(lat2), 32'd33);

        $display("[TB] reset mid-operation");
        fun32 = 3'b101; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_result", res32, 32'h0);
        checkOutput("midrst_busy", {31'h0, busy32}, 32'h0);
        checkOutput("midrst_done", {31'h0, done32}, 32'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done32) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32) seen_done = 1'b1;
        end
        checkOutput("midrst_no_done", {31'h0, seen_done}, 32'h0);
        applyStimulus(0, 3'b000, 32'd3, 32'd4, got, lat);
        checkOutput("post_rst_mul", got, 32'd12);
        checkOutput("post_rst_lat", 32'(lat), 32'd33);

        $display("[TB] random sweep XLEN=32");
        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            applyStimulus(0, rf, ra, rb, got, lat);
            checkOutput("rand32_res", got, ref_model(rf, ra, rb, 32));
            checkOutput("rand32_lat", 32'(lat), 32'(exp_lat(rf, ra, rb, 32)));
        end

        $display("[TB] random sweep XLEN=8");
        for (int n = 0; n < 4000; n++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 9) == 0) ? 32'h80 : ($urandom & 32'hFF);
            case ($urandom_range(0, 9))
                0:       rb = 32'h0;
                1:       rb = 32'hFF;
                default: rb = $urandom & 32'hFF;
            endcase
            applyStimulus(1, rf, ra, rb, got, lat);
            checkOutput("rand8_res", got, ref_model(rf, ra, rb, 8));
            checkOutput("rand8_lat", 32'(lat), 32'(exp_lat(rf, ra, rb, 8)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
